// File: rtl/serial_link_nibble_rx_if.sv
// serial_link_nibble_rx_if: word pop port and status flags of the nibble receiver
interface serial_link_nibble_rx_if;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        fifo_empty_o;
  logic        fifo_full_o;
  logic        overflow_o;
  logic        frame_err_o;
  modport master (
    output word_o, word_valid_o, fifo_empty_o, fifo_full_o, overflow_o, frame_err_o,
    input  word_ready_i
  );
  modport slave (
    input  word_o, word_valid_o, fifo_empty_o, fifo_full_o, overflow_o, frame_err_o,
    output word_ready_i
  );
endinterface

// File: rtl/serial_link_nibble_rx.sv
// serial_link_nibble_rx: synchronises a 4-bit toggle-strobed lane and assembles nibbles into a word FIFO
module serial_link_nibble_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [3:0]              lane_i,
  input  logic                    lane_tgl_i,
  input  logic                    clear_i,
  serial_link_nibble_rx_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int MW = $clog2(SYNC_STAGES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, ASSEMBLE} state_t;
  logic [SYNC_STAGES-1:0][3:0] r_lane_s;
  logic [SYNC_STAGES-1:0]      r_tgl_s;
  logic                        r_tgl_q;
  logic [MW-1:0]               r_mask;
  state_t                      r_state;
  logic [2:0]                  r_cnt;
  logic [TW-1:0]               r_tcnt;
  logic [31:0]                 r_acc;
  logic                        r_push;
  logic                        r_ferr;
  logic [FIFO_DEPTH-1:0][31:0] r_mem;
  logic [AW:0]                 r_wp;
  logic [AW:0]                 r_rp;
  logic [31:0]                 r_last;
  logic                        r_ovf;
  logic [3:0]                  w_lane;
  logic                        w_evt;
  logic                        w_empty;
  logic                        w_full;
  logic                        w_pop;
  logic                        w_wr;
  assign w_lane  = r_lane_s[SYNC_STAGES-1];
  assign w_evt   = (r_tgl_s[SYNC_STAGES-1] != r_tgl_q) && (r_mask == '0);
  assign w_empty = r_wp == r_rp;
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = !w_empty && bus.word_ready_i;
  assign w_wr    = r_push && !clear_i && (!w_full || w_pop);
  assign bus.word_o       = w_empty ? r_last : r_mem[r_rp[AW-1:0]];
  assign bus.word_valid_o = !w_empty;
  assign bus.fifo_empty_o = w_empty;
  assign bus.fifo_full_o  = w_full;
  assign bus.overflow_o   = r_ovf;
  assign bus.frame_err_o  = r_ferr;
  // synchronisers, toggle history and the post-reset event mask
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      r_lane_s <= '0;
      r_tgl_s  <= '0;
      r_tgl_q  <= 1'b0;
      r_mask   <= MW'(SYNC_STAGES + 1);
    end else begin
      r_lane_s <= {r_lane_s[SYNC_STAGES-2:0], lane_i};
      r_tgl_s  <= {r_tgl_s[SYNC_STAGES-2:0], lane_tgl_i};
      r_tgl_q  <= r_tgl_s[SYNC_STAGES-1];
      r_mask   <= (r_mask != '0) ? r_mask - MW'(1) : r_mask;
    end
  // nibble assembly FSM; the completed word is held in r_acc and pushed on the following edge
  always_ff @(posedge clk_i)
    if (!rst_ni || clear_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_push  <= 1'b0;
      r_ferr  <= 1'b0;
      r_acc   <= rst_ni ? r_acc : '0;
    end else begin
      r_push <= 1'b0;
      if (w_evt) begin
        r_acc[{r_cnt, 2'b00} +: 4] <= w_lane;
        r_cnt   <= r_cnt + 3'd1;
        r_tcnt  <= '0;
        r_push  <= r_cnt == 3'd7;
        r_state <= (r_cnt == 3'd7) ? IDLE : ASSEMBLE;
      end else if (r_state == ASSEMBLE && r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_tcnt  <= '0;
        r_ferr  <= 1'b1;
      end else if (r_state == ASSEMBLE) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  // show-ahead word FIFO with overflow tracking; r_last holds the most recently popped word
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      r_mem  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_last <= '0;
      r_ovf  <= 1'b0;
    end else if (clear_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp[AW-1:0]] <= r_acc;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_last <= r_mem[r_rp[AW-1:0]];
        r_rp   <= r_rp + 1'b1;
      end
      if (r_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
endmodule
